tremolo_modulator: RTL and testbench

- Audio datapath stage directly downstream of the AXI-lite tremolo parameter register block.
- Consumes that block's rate, depth, waveform and enable registers and applies LFO amplitude modulation to a valid/ready sample stream.
- Contents: phase-accumulator LFO, gain computation, 3-stage multiply pipeline with full backpressure.
- Parameters are shadowed and applied only at LFO period boundaries, so register writes never cause zipper noise mid-cycle.

---
 rtl/tremolo_modulator.sv | 144 ++++++++++++++
 tb/tb_tremolo_modulator.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/tremolo_modulator.sv
// Purpose : LFO amplitude modulation (tremolo) on a valid/ready signed audio sample stream.
// Latency : 3 register stages; a sample presented in cycle c appears on m_data in cycle c+3, one per cycle.
// Backpressure: s_ready = !m_valid | m_ready; a stall freezes every stage register and the LFO phase.
//
// Ports:
//   clock, reset            single clock, synchronous active-high reset
//   cfg_enable/wave/rate/depth   live register values; shadowed and applied only at LFO wrap
//                                (or continuously while the shadowed enable is low)
//   s_valid/s_ready/s_data  input sample stream (signed DATA_W)
//   m_valid/m_ready/m_data  output sample stream (signed DATA_W)
module tremolo_modulator #(
    parameter int DATA_W  = 24,
    parameter int PHASE_W = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     cfg_enable,
    input  logic                     cfg_wave,
    input  logic [PHASE_W-1:0]       cfg_rate,
    input  logic [15:0]              cfg_depth,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic signed [DATA_W-1:0] s_data,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic signed [DATA_W-1:0] m_data
);

    // Sample (signed) times gain (17-bit unsigned, carried as 18-bit signed).
    localparam int MUL_W = DATA_W + 18;

    // Flow control
    logic adv;
    logic accept;

    // LFO phase and shadowed parameters
    logic [PHASE_W-1:0] phase;
    logic [PHASE_W-1:0] phase_sum;
    logic               carry;
    logic               wrap;
    logic               shadow_load;
    logic               sh_en;
    logic               sh_wave;
    logic [PHASE_W-1:0] sh_rate;
    logic [15:0]        sh_depth;
    logic [15:0]        lfo;
    logic [15:0]        lfo_inv;

    // Pipeline stages
    logic                     s1_vld;
    logic signed [DATA_W-1:0] s1_data;
    logic [31:0]              s1_prod;
    logic                     s1_en;
    logic                     s2_vld;
    logic signed [DATA_W-1:0] s2_data;
    logic [16:0]              s2_gain;
    logic signed [MUL_W-1:0]  mult;

    always_comb begin
        adv     = !m_valid || m_ready;
        s_ready = adv;
        accept  = s_valid && adv;

        {carry, phase_sum} = {1'b0, phase} + {1'b0, sh_rate};

        // Parameters follow the registers freely while bypassed; once enabled they
        // only move at a period boundary so the gain curve never jumps mid-period.
        wrap        = accept && sh_en && carry;
        shadow_load = !sh_en || wrap;

        // LFO is taken from the phase before this sample's increment.
        if (sh_wave) begin
            lfo = phase[PHASE_W-1] ? 16'h0000 : 16'hFFFF;
        end else begin
            lfo = phase[PHASE_W-1] ? ~phase[PHASE_W-2 -: 16] : phase[PHASE_W-2 -: 16];
        end
        lfo_inv = 16'hFFFF - lfo;

        mult = $signed(s2_data) * $signed({1'b0, s2_gain});
    end

    // Shadow parameter registers
    always_ff @(posedge clock) begin
        if (reset) begin
            sh_en    <= 1'b0;
            sh_wave  <= 1'b0;
            sh_rate  <= '0;
            sh_depth <= '0;
        end else if (shadow_load) begin
            sh_en    <= cfg_enable;
            sh_wave  <= cfg_wave;
            sh_rate  <= cfg_rate;
            sh_depth <= cfg_depth;
        end
    end

    // Phase accumulator: advances only on accepted samples; held at zero while
    // bypassed so enabling always starts the LFO from the top of its period.
    always_ff @(posedge clock) begin
        if (reset) begin
            phase <= '0;
        end else if (accept) begin
            phase <= sh_en ? phase_sum : '0;
        end
    end

    // Three-stage datapath, all stages gated by the common advance.
    always_ff @(posedge clock) begin
        if (reset) begin
            s1_vld  <= 1'b0;
            s1_data <= '0;
            s1_prod <= '0;
            s1_en   <= 1'b0;
            s2_vld  <= 1'b0;
            s2_data <= '0;
            s2_gain <= '0;
            m_valid <= 1'b0;
            m_data  <= '0;
        end else if (adv) begin
            // Stage 1: depth-scaled attenuation product
            s1_vld <= s_valid;
            if (accept) begin
                s1_data <= s_data;
                s1_prod <= sh_depth * lfo_inv;
                s1_en   <= sh_en;
            end

            // Stage 2: gain in 1..65536; bypass is unity gain
            s2_vld <= s1_vld;
            if (s1_vld) begin
                s2_data <= s1_data;
                s2_gain <= s1_en ? (17'h10000 - 17'(s1_prod >> 16)) : 17'h10000;
            end

            // Stage 3: apply gain; arithmetic shift gives floor rounding and
            // |result| <= |sample| so no saturation is required
            m_valid <= s2_vld;
            if (s2_vld) begin
                m_data <= DATA_W'(mult >>> 16);
            end
        end
    end

endmodule

// File: tb/tb_tremolo_modulator.sv
// Directed bench for tremolo_modulator: table of per-configuration vectors plus
// hand-written sequences for throughput, stall, shadow timing and mid-stream reset.
module tb_tremolo_modulator;

    logic        clock;
    logic        reset;
    logic        cfg_enable;
    logic        cfg_wave;
    logic [31:0] cfg_rate;
    logic [15:0] cfg_depth;
    logic        s_valid;
    logic        s_ready;
    logic [23:0] s_data;
    logic        m_valid;
    logic        m_ready;
    logic [23:0] m_data;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [23:0] outq[$];
    int          outcyc[$];
    int          accq[$];

    typedef struct packed {
        logic             en;
        logic             wave;
        logic [15:0]      depth;
        logic [31:0]      rate;
        logic [23:0]      din;
        logic [0:3][23:0] exp;
    } vec_t;

    vec_t vecs[9];

    tremolo_modulator #(.DATA_W(24), .PHASE_W(32)) dut (
        .clock      (clock),
        .reset      (reset),
        .cfg_enable (cfg_enable),
        .cfg_wave   (cfg_wave),
        .cfg_rate   (cfg_rate),
        .cfg_depth  (cfg_depth),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Output monitor: values at the falling edge equal those at the next rising edge.
    always @(negedge clock) begin
        if (!reset && m_valid && m_ready) begin
            outq.push_back(m_data);
            outcyc.push_back(cyc);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_cfg(input logic en, input logic wave, input logic [15:0] depth,
                           input logic [31:0] rate);
        cfg_enable = en;
        cfg_wave   = wave;
        cfg_depth  = depth;
        cfg_rate   = rate;
    endtask

    // Reset, then one idle edge so the bypassed shadow picks up cfg_*.
    task automatic restart(input string nm);
        s_valid = 1'b0;
        reset   = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        check({nm, "_rst_m_valid"}, {31'd0, m_valid}, 32'd0);
        check({nm, "_rst_m_data"},  {8'd0, m_data},   32'd0);
        check({nm, "_rst_s_ready"}, {31'd0, s_ready}, 32'd1);
        tick();
        outq.delete();
        outcyc.delete();
        accq.delete();
    endtask

    task automatic send(input logic [23:0] d);
        bit ok;
        ok      = 1'b0;
        s_valid = 1'b1;
        s_data  = d;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            if (s_ready) begin
                ok = 1'b1;
                accq.push_back(cyc);
                break;
            end
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: got s_ready=0 for 50 cycles expected acceptance");
        end
        @(posedge clock);
        #1;
        s_valid = 1'b0;
    endtask

    // Wait for n outputs, then a few idle cycles to catch any extra ones.
    task automatic wait_outs(input string nm, input int n);
        for (int i = 0; i < 200 && outq.size() < n; i++) @(negedge clock);
        repeat (5) tick();
        check({nm, "_out_count"}, outq.size(), n);
    endtask

    task automatic cmp_out(input string nm, input int k, input logic [23:0] exp);
        if (k < outq.size()) check($sformatf("%s_out%0d", nm, k), {8'd0, outq[k]}, {8'd0, exp});
        else check($sformatf("%s_out%0d_missing", nm, k), 32'hFFFF_FFFF, {8'd0, exp});
    endtask

    initial begin
        logic [23:0] d[20];
        logic [23:0] e[8];

        reset = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b1;
        set_cfg(1'b0, 1'b0, 16'h0, 32'h0);

        //            en    wave  depth     rate          din        expected outputs 0..3
        vecs[0] = '{1'b1, 1'b1, 16'hFFFF, 32'h8000_0000, 24'h100000, {24'h100000, 24'h000020, 24'h100000, 24'h000020}};
        vecs[1] = '{1'b1, 1'b1, 16'hFFFF, 32'h8000_0000, 24'hF00000, {24'hF00000, 24'hFFFFE0, 24'hF00000, 24'hFFFFE0}};
        vecs[2] = '{1'b1, 1'b0, 16'hFFFF, 32'h4000_0000, 24'h100000, {24'h000020, 24'h080020, 24'h100000, 24'h080010}};
        vecs[3] = '{1'b1, 1'b0, 16'hFFFF, 32'h4000_0000, 24'h7FFFFF, {24'h0000FF, 24'h4000FF, 24'h7FFFFF, 24'h40007F}};
        vecs[4] = '{1'b1, 1'b0, 16'hFFFF, 32'h4000_0000, 24'h800000, {24'hFFFF00, 24'hBFFF00, 24'h800000, 24'hBFFF80}};
        vecs[5] = '{1'b1, 1'b0, 16'hFFFF, 32'h4000_0000, 24'hFFFFFF, {24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF}};
        vecs[6] = '{1'b1, 1'b1, 16'h8000, 32'h8000_0000, 24'h100000, {24'h100000, 24'h080010, 24'h100000, 24'h080010}};
        vecs[7] = '{1'b0, 1'b1, 16'hFFFF, 32'h8000_0000, 24'h123456, {24'h123456, 24'h123456, 24'h123456, 24'h123456}};
        vecs[8] = '{1'b1, 1'b0, 16'hFFFF, 32'h0000_0000, 24'h100000, {24'h000020, 24'h000020, 24'h000020, 24'h000020}};

        for (int v = 0; v < 9; v++) begin
            string nm;
            nm = $sformatf("vec%0d", v);
            set_cfg(vecs[v].en, vecs[v].wave, vecs[v].depth, vecs[v].rate);
            restart(nm);
            for (int k = 0; k < 4; k++) send(vecs[v].din);
            wait_outs(nm, 4);
            for (int k = 0; k < 4; k++) cmp_out(nm, k, vecs[v].exp[k]);
        end

        // Unity depth: exact pass-through, 3-cycle latency, one output per cycle.
        set_cfg(1'b1, 1'b0, 16'h0000, 32'h1234_5678);
        restart("unity");
        for (int k = 0; k < 20; k++) d[k] = 24'($urandom());
        for (int k = 0; k < 20; k++) send(d[k]);
        wait_outs("unity", 20);
        for (int k = 0; k < 20; k++) cmp_out("unity", k, d[k]);
        if (outcyc.size() == 20 && accq.size() == 20) begin
            check("unity_latency", 32'(outcyc[0] - accq[0]), 32'd3);
            check("unity_throughput", 32'(outcyc[19] - outcyc[0]), 32'd19);
        end else begin
            check("unity_timing_records", 32'(outcyc.size()), 32'd20);
        end

        // Backpressure: 5-cycle stall with a sample waiting upstream.
        set_cfg(1'b1, 1'b1, 16'hFFFF, 32'h8000_0000);
        m_ready = 1'b0;
        restart("stall");
        for (int k = 0; k < 8; k++) e[k] = (k % 2 == 0) ? 24'((k + 1) << 16) : 24'((k + 1) * 2);
        for (int k = 0; k < 3; k++) send(24'((k + 1) << 16));
        s_valid = 1'b1;
        s_data  = 24'(4 << 16);
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            check($sformatf("stall_m_valid_c%0d", k), {31'd0, m_valid}, 32'd1);
            check($sformatf("stall_s_ready_c%0d", k), {31'd0, s_ready}, 32'd0);
            check($sformatf("stall_m_data_c%0d", k),  {8'd0, m_data},   {8'd0, e[0]});
        end
        @(posedge clock);
        #1;
        m_ready = 1'b1;
        for (int k = 3; k < 8; k++) send(24'((k + 1) << 16));
        wait_outs("stall", 8);
        for (int k = 0; k < 8; k++) cmp_out("stall", k, e[k]);

        // Shadow timing: depth written after the 2nd sample applies only after the wrap.
        set_cfg(1'b1, 1'b0, 16'hFFFF, 32'h4000_0000);
        restart("shadow");
        send(24'h100000);
        send(24'h100000);
        cfg_depth = 16'h0000;
        for (int k = 0; k < 6; k++) send(24'h100000);
        wait_outs("shadow", 8);
        e = '{24'h000020, 24'h080020, 24'h100000, 24'h080010,
              24'h100000, 24'h100000, 24'h100000, 24'h100000};
        for (int k = 0; k < 8; k++) cmp_out("shadow", k, e[k]);

        // Reset with three samples in flight: none may ever appear.
        set_cfg(1'b1, 1'b1, 16'hFFFF, 32'h8000_0000);
        m_ready = 1'b0;
        restart("midrst");
        for (int k = 0; k < 3; k++) send(24'h0ABCDE);
        check("midrst_pre_m_valid", {31'd0, m_valid}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_m_valid", {31'd0, m_valid}, 32'd0);
        check("midrst_m_data",  {8'd0, m_data},   32'd0);
        check("midrst_s_ready", {31'd0, s_ready}, 32'd1);
        m_ready = 1'b1;
        outq.delete();
        repeat (10) tick();
        check("midrst_no_outputs", outq.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
